nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle W-bit adder (W = 4*N_NIBBLES) that reuses one 4-bit ripple carry adder (rca4).
//  Each clock adds one nibble, LSB nibble first, and registers the carry between nibbles.
//  Sits in the datapath in place of a wide combinational adder where area matters more than latency.
//  Uses a start/done handshake and holds its result until the next start.
// PARAMETERS
//  N_NIBBLES  4  number of 4-bit slices; operand width W = 4*N_NIBBLES (legal: N_NIBBLES >= 1)
// PORTS
//  clk      in   1  single clock, rising-edge
//  reset_n  in   1  asynchronous, active-low reset
//  start    in   1  request; sampled only in IDLE
//  a        in   W  operand A; captured on the accepted start edge
//  b        in   W  operand B; captured on the accepted start edge
//  ci       in   1  carry-in to nibble 0; captured with a/b
//  busy     out  1  high from the edge after an accepted start through the DONE cycle
//  done     out  1  one-cycle pulse; s/co/ovf are valid in that cycle and after it
//  s        out  W  sum; held until the next accepted start completes
//  co       out  1  carry out of the MSB nibble
//  ovf      out  1  signed overflow: (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1])
// BEHAVIOUR
//  Reset: async assert (reset_n=0) forces state=IDLE and clears all registers.
//   busy=0, done=0, s=0, co=0, ovf=0. Reset is honoured in any state; an operation in flight is discarded.
//  FSM states: IDLE -> ADD -> DONE -> IDLE.
//   IDLE: if start=1, latch A_sh=a, B_sh=b, c=ci, cnt=0, then go to ADD. If start=0, stay in IDLE.
//   ADD, each edge:
//    - {c, nib} = rca4(A_sh[3:0], B_sh[3:0], c)
//    - S_sh = {nib, S_sh[W-1:4]}
//    - A_sh and B_sh shift right by 4
//    - cnt++
//    - when cnt==N_NIBBLES-1, go to DONE
//   DONE: s<=S_sh, co<=c, ovf per formula using the latched MSBs; done=1 for this cycle only; next state IDLE.
//  Outputs s/co/ovf are registered and change only on the DONE-entry edge.
//  Latency: start sampled at edge E0; done is high in the cycle after edge E0+N_NIBBLES+1.
//   For N_NIBBLES=4, done is high in the cycle after E0+5. Next start is accepted at the earliest one edge later (IDLE).
//  start while busy (ADD or DONE) is ignored, not queued. a/b/ci may change freely after capture.
//  Arithmetic: modulo 2^W; carry propagates nibble to nibble exactly as in a single W-bit ripple adder.
//  N_NIBBLES=1: ADD lasts one cycle. The cnt width is max(1, clog2(N_NIBBLES)).
//  Back-to-back: holding start=1 continuously yields one operation every N_NIBBLES+2 cycles.
//  No X propagation: all state registers are reset.
// STRUCTURE
//  Shared include (adder_defs.vh):
//   - state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2
//   - NIBBLE=4 constant
//  One sub-module: existing rca4, instantiated exactly once as the nibble datapath.
//  Everything else (FSM, shift registers, counter) lives in this module. No other sub-modules.
// TESTING (default N_NIBBLES=4 unless stated)
//  1. a=16'h1234, b=16'h4321, ci=0, start pulse -> done after 5 edges; s=16'h5555, co=0, ovf=0.
//  2. a=16'hFFFF, b=16'h0001, ci=0 -> s=16'h0000, co=1, ovf=0 (full carry ripple across all nibbles).
//  3. a=16'h7FFF, b=16'h0001, ci=0 -> s=16'h8000, co=0, ovf=1. Then a=16'h8000, b=16'h8000 -> s=0, co=1, ovf=1.
//  4. a=0, b=0, ci=1 -> s=16'h0001. Pulse start again at the 2nd ADD cycle -> ignored; exactly one done pulse.
//  5. Assert reset_n=0 mid-ADD (after 2 nibbles) -> busy/done/s/co/ovf=0 immediately, no done pulse.
//     Next op 16'h00FF+16'h0001 -> s=16'h0100.
//  6. N_NIBBLES=1: a=4'hF, b=4'h1, ci=1 -> done 2 edges after start; s=4'h1, co=1. Also run 1000 random ops vs a+b+ci.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM state type for the nibble-serial adder.
// The cnt_width helper sizes the nibble counter for any legal slice count.
package nibble_serial_adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// Four-bit ripple carry adder used as the single shared nibble datapath.
module rca4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] i_a,
  input  logic [NIBBLE-1:0] i_b,
  input  logic              i_ci,
  output logic [NIBBLE-1:0] o_s,
  output logic              o_co
);

  logic [NIBBLE:0] w_c;

  assign w_c[0] = i_ci;

  genvar gi;
  for (gi = 0; gi < NIBBLE; gi++) begin : g_fa
    assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_co = w_c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one nibble per clock through a shared rca4, LSB first,
// with a start/done handshake and results held until the next operation completes.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int N_NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [NIBBLE*N_NIBBLES-1:0] a,
  input  logic [NIBBLE*N_NIBBLES-1:0] b,
  input  logic                        ci,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE*N_NIBBLES-1:0] s,
  output logic                        co,
  output logic                        ovf
);

  localparam int W     = NIBBLE * N_NIBBLES;
  localparam int CNT_W = cnt_width(N_NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_NIBBLES - 1);

  state_t           r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_s_sh;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_s;
  logic             r_co;
  logic             r_ovf;

  logic [NIBBLE-1:0] w_nib;
  logic              w_nib_co;
  logic [W-1:0]      w_s_next;

  rca4 u_rca4 (
    .i_a  (r_a_sh[NIBBLE-1:0]),
    .i_b  (r_b_sh[NIBBLE-1:0]),
    .i_ci (r_c),
    .o_s  (w_nib),
    .o_co (w_nib_co)
  );

  // New nibble enters at the top so that after N_NIBBLES shifts nibble 0 sits at the bottom.
  if (N_NIBBLES == 1) begin : g_s_single
    assign w_s_next = w_nib;
  end else begin : g_s_multi
    assign w_s_next = {w_nib, r_s_sh[W-1:NIBBLE]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // busy covers the done cycle, which the FSM spends back in IDLE.
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_c     <= ci;
            r_cnt   <= '0;
            r_a_msb <= a[W-1];
            r_b_msb <= b[W-1];
            r_busy  <= 1'b1;
            r_state <= ST_ADD;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_ADD: begin
          r_a_sh <= r_a_sh >> NIBBLE;
          r_b_sh <= r_b_sh >> NIBBLE;
          r_s_sh <= w_s_next;
          r_c    <= w_nib_co;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_s     <= r_s_sh;
          r_co    <= r_c;
          r_ovf   <= (r_a_msb == r_b_msb) && (r_s_sh[W-1] != r_a_msb);
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at N_NIBBLES=4 and N_NIBBLES=1,
// comparing against plain a+b+ci arithmetic.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic reset_n;

  logic        start4, ci4, busy4, done4, co4, ovf4;
  logic [15:0] a4, b4, s4;
  logic        start1, ci1, busy1, done1, co1, ovf1;
  logic [3:0]  a1, b1, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.N_NIBBLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  nibble_serial_adder #(.N_NIBBLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  // One full operation on either instance; checks latency, busy, results and pulse width.
  task automatic run_op(input bit n1, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tci, input string name);
    int          w;
    int          lat;
    int          k;
    logic [15:0] mask;
    logic [16:0] full;
    logic [15:0] es, gs;
    logic        eco, eovf, gco, govf, gdone, gbusy;
    w    = n1 ? 4 : 16;
    lat  = n1 ? 2 : 5;
    mask = n1 ? 16'h000F : 16'hFFFF;
    ta   = ta & mask;
    tbv  = tbv & mask;
    full = {1'b0, ta} + {1'b0, tbv} + 17'(tci);
    es   = full[15:0] & mask;
    eco  = full[w];
    eovf = (ta[w-1] == tbv[w-1]) && (es[w-1] != ta[w-1]);

    @(negedge clk);
    if (n1) begin start1 = 1'b1; a1 = ta[3:0]; b1 = tbv[3:0]; ci1 = tci; end
    else    begin start4 = 1'b1; a4 = ta;      b4 = tbv;      ci4 = tci; end
    @(negedge clk);
    // Operands are scrambled after capture; the result must not depend on them.
    if (n1) begin start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom); ci1 = 1'($urandom); end
    else    begin start4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom); ci4 = 1'($urandom); end

    k = 0;
    gdone = 1'b0;
    while (!gdone && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      gdone = n1 ? done1 : done4;
      gbusy = n1 ? busy1 : busy4;
      if (k == 1) begin
        checks++;
        if (gbusy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b expected 1", name, gbusy);
        end
      end
    end
    checks++;
    if (!gdone || k != lat) begin
      errors++;
      $display("FAIL %s latency: done seen=%b after %0d edges, expected %0d", name, gdone, k, lat);
    end

    gs   = n1 ? {12'h000, s1} : s4;
    gco  = n1 ? co1 : co4;
    govf = n1 ? ovf1 : ovf4;
    checks++;
    if (gs !== es || gco !== eco || govf !== eovf) begin
      errors++;
      $display("FAIL %s result: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
               name, gs, gco, govf, es, eco, eovf);
    end
    $display("op %s: a=%h b=%h ci=%b -> s=%h co=%b ovf=%b", name, ta, tbv, tci, gs, gco, govf);

    @(posedge clk);
    #1;
    gdone = n1 ? done1 : done4;
    gbusy = n1 ? busy1 : busy4;
    gs    = n1 ? {12'h000, s1} : s4;
    checks++;
    if (gdone !== 1'b0 || gbusy !== 1'b0 || gs !== es) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b s=%h expected done=0 busy=0 s=%h",
               name, gdone, gbusy, gs, es);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start4 = 1'b0; a4 = 16'hFFFF; b4 = 16'hFFFF; ci4 = 1'b1;
    start1 = 1'b0; a1 = 4'hF;     b1 = 4'hF;     ci1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, s4, co4, ovf4, busy1, done1, s1, co1, ovf1} !== '0) begin
      errors++;
      $display("FAIL reset: got busy4=%b done4=%b s4=%h co4=%b ovf4=%b busy1=%b done1=%b s1=%h expected all zero",
               busy4, done4, s4, co4, ovf4, busy1, done1, s1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy4, done4, s4, busy1, done1, s1} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy4=%b done4=%b s4=%h busy1=%b done1=%b expected all zero",
               busy4, done4, s4, busy1, done1);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_directed();
    run_op(1'b0, 16'h1234, 16'h4321, 1'b0, "basic");
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, "full_ripple");
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    run_op(1'b0, 16'h8000, 16'h8000, 1'b0, "neg_ovf");
    run_op(1'b0, 16'h0000, 16'h0000, 1'b1, "carry_in");
  endtask

  task automatic test_start_ignored();
    int pulses;
    int pulse_at;
    logic [15:0] s_at;
    @(negedge clk);
    a4 = 16'h0000; b4 = 16'h0000; ci4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; ci4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    pulses = 0; pulse_at = -1; s_at = 16'hxxxx;
    for (int i = 3; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (done4) begin
        pulses++;
        pulse_at = i;
        s_at = s4;
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 5) begin
      errors++;
      $display("FAIL start_ignored pulses: got %0d pulses (last after edge %0d) expected 1 after edge 5",
               pulses, pulse_at);
    end
    checks++;
    if (s_at !== 16'h0001) begin
      errors++;
      $display("FAIL start_ignored result: got s=%h expected 0001", s_at);
    end
    $display("start_ignored: pulses=%0d s=%h", pulses, s_at);
  endtask

  task automatic test_reset_mid_add();
    int pulses;
    @(negedge clk);
    a4 = 16'hABCD; b4 = 16'h1111; ci4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, s4, co4, ovf4} !== '0) begin
      errors++;
      $display("FAIL reset_mid_add: got busy=%b done=%b s=%h co=%b ovf=%b expected all zero",
               busy4, done4, s4, co4, ovf4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done4 || busy4) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_discard: got %0d cycles with done/busy set expected 0", pulses);
    end
    $display("reset_mid_add: operation discarded");
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, "after_reset");
  endtask

  task automatic test_n1();
    run_op(1'b1, 16'h000F, 16'h0001, 1'b1, "n1_directed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "rand4");
    for (int i = 0; i < 1000; i++)
      run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rand1");
  endtask

  // Start held high: an operation is accepted every 6 edges; operands change every cycle.
  task automatic test_back_to_back();
    logic [15:0] qa[24];
    logic [15:0] qb[24];
    logic        qc[24];
    logic [16:0] full;
    logic        exp_done;
    logic [15:0] es;
    logic        eco, eovf;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      qa[i] = 16'($urandom); qb[i] = 16'($urandom); qc[i] = 1'($urandom);
      start4 = 1'b1; a4 = qa[i]; b4 = qb[i]; ci4 = qc[i];
      @(posedge clk);
      #1;
      exp_done = (i % 6 == 5);
      checks++;
      if (done4 !== exp_done || busy4 !== 1'b1) begin
        errors++;
        $display("FAIL b2b handshake at edge %0d: got done=%b busy=%b expected done=%b busy=1",
                 i, done4, busy4, exp_done);
      end
      if (exp_done) begin
        full = {1'b0, qa[i-5]} + {1'b0, qb[i-5]} + 17'(qc[i-5]);
        es   = full[15:0];
        eco  = full[16];
        eovf = (qa[i-5][15] == qb[i-5][15]) && (es[15] != qa[i-5][15]);
        checks++;
        if (s4 !== es || co4 !== eco || ovf4 !== eovf) begin
          errors++;
          $display("FAIL b2b result at edge %0d: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
                   i, s4, co4, ovf4, es, eco, eovf);
        end
        $display("b2b: a=%h b=%h ci=%b -> s=%h co=%b ovf=%b", qa[i-5], qb[i-5], qc[i-5], s4, co4, ovf4);
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL b2b drain: got busy=%b done=%b expected 0 0", busy4, done4);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_add();
    test_n1();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
